// File: rtl/mdu_pkg.sv
// Shared RV32M definitions: funct3 opcodes, FSM states, iteration count, funct7 tag.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mdu_pkg;

    localparam int ITER_COUNT = 32;

    // funct7 value that selects the M extension on OP instructions
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider datapath on unsigned magnitudes, one quotient bit per step.
// Latency: next quotient/remainder are combinational; partials register on init/step edges.
// Backpressure: none; the owning FSM decides when to init and step.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_nxt,
    output logic [31:0] rem_nxt
);

    logic [31:0] rem_q, quo_q, dvs_q;
    logic [31:0] cur_rem, cur_quo, cur_dvs;
    logic [32:0] shifted;
    logic        fits;

    // One restoring step, taken on fresh operands at launch or on the held partials.
    // The quotient register starts as the dividend and shifts its bits out into the remainder.
    always_comb begin
        cur_rem = init ? 32'd0 : rem_q;
        cur_quo = init ? dividend : quo_q;
        cur_dvs = init ? divisor : dvs_q;
        shifted = {cur_rem, cur_quo[31]};
        fits    = (shifted >= {1'b0, cur_dvs});
        rem_nxt = fits ? 32'(shifted - {1'b0, cur_dvs}) : shifted[31:0];
        quo_nxt = {cur_quo[30:0], fits};
    end

    // Partials advance on the launch edge and on every iteration edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (init || step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (init) dvs_q <= divisor;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// RV32M multiply/divide unit: 32 iterations (first one on the launch edge), option MDU_FAST_MUL_EN.
// Latency: done in T+32 for iterative ops, T+1 for div-by-zero/overflow (and MUL* when MDU_FAST_MUL_EN).
// Backpressure: busy stalls the pipeline; start is ignored while busy; flush aborts without done.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_t  state_q, state_nxt;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [63:0] acc_q;
    logic [31:0] mcand_q;
    logic [31:0] result_q;
    logic        done_q;

    logic        a_signed, b_signed, sa, sb, is_div, fast_path;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf, special, launch_neg;
    logic [31:0] special_res, accept_res;
    logic        accept, launch, last;
    logic [63:0] cur_acc, acc_nxt, prod;
    logic [31:0] cur_mcand;
    logic [32:0] mul_sum;
    logic [31:0] quo_nxt, rem_nxt, quo_fix, rem_fix, final_res;
`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod, fast_fix;
`endif

    // Operand decode: signedness, magnitudes, and the cases that finish without iterating.
    always_comb begin
        a_signed    = funct3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
        b_signed    = funct3 inside {MDU_MULH, MDU_DIV, MDU_REM};
        sa          = a_signed && op_a[31];
        sb          = b_signed && op_b[31];
        mag_a       = sa ? -op_a : op_a;
        mag_b       = sb ? -op_b : op_b;
        is_div      = funct3[2];
        div_zero    = is_div && (op_b == 32'd0);
        div_ovf     = (funct3 == MDU_DIV || funct3 == MDU_REM) &&
                      (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        special     = div_zero || div_ovf;
        special_res = div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                               : (funct3[1] ? 32'd0 : 32'h8000_0000);
        // remainder follows the dividend's sign; quotient and product follow the sign xor
        launch_neg  = (is_div && funct3[1]) ? sa : (sa ^ sb);
`ifdef MDU_FAST_MUL_EN
        fast_path   = !is_div;
        fast_prod   = {32'd0, mag_a} * {32'd0, mag_b};
        fast_fix    = (sa ^ sb) ? -fast_prod : fast_prod;
        accept_res  = special ? special_res
                              : ((funct3 == MDU_MUL) ? fast_fix[31:0] : fast_fix[63:32]);
`else
        fast_path   = 1'b0;
        accept_res  = special_res;
`endif
        accept      = (state_q == IDLE) && start && !flush;
        launch      = accept && !special && !fast_path;
        last        = (state_q == CALC) && (cnt_q == 5'(ITER_COUNT - 1));
    end

    // Shift-add multiply step and final sign correction for both datapaths.
    always_comb begin
        cur_acc   = launch ? {32'd0, mag_b} : acc_q;
        cur_mcand = launch ? mag_a : mcand_q;
        mul_sum   = {1'b0, cur_acc[63:32]} + (cur_acc[0] ? {1'b0, cur_mcand} : 33'd0);
        acc_nxt   = {mul_sum, cur_acc[31:1]};
        prod      = neg_q ? -acc_nxt : acc_nxt;
        quo_fix   = neg_q ? -quo_nxt : quo_nxt;
        rem_fix   = neg_q ? -rem_nxt : rem_nxt;
        if (op_q[2])
            final_res = op_q[1] ? rem_fix : quo_fix;
        else
            final_res = (op_q == MDU_MUL) ? prod[31:0] : prod[63:32];
    end

    mdu_div_core u_div_core (
        .clk      (clk),
        .reset    (reset),
        .init     (launch),
        .step     ((state_q == CALC) && !flush),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // FSM next state and busy.
    always_comb begin
        state_nxt = state_q;
        busy      = 1'b0;
        case (state_q)
            IDLE: if (launch) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (flush || last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: launch, iterate, register the result; flush outranks everything but reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                cnt_q <= '0;
            end else if (launch) begin
                op_q    <= funct3;
                neg_q   <= launch_neg;
                acc_q   <= acc_nxt;
                mcand_q <= mag_a;
                cnt_q   <= 5'd1;
            end else if (accept) begin
                result_q <= accept_res;
                done_q   <= 1'b1;
            end else if (state_q == CALC) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + 5'd1;
                if (last) begin
                    result_q <= final_res;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: cycle model plus directed vectors with literal expectations.
// Latency: checks done timing (T+1 / T+32) and busy every cycle.
// Backpressure: exercises start-while-busy, flush, reset and back-to-back starts.
module tb_mdu_unit;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdu_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an RV32M op, from 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            MDU_MUL:    begin p = ua * ub; return p[31:0];  end
            MDU_MULH:   begin p = sa * sb; return p[63:32]; end
            MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
            MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
            MDU_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = $signed(sa) / $signed(sb); return p[31:0]; end
            MDU_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            MDU_REM:    begin if (b == 0) return a; p = $signed(sa) % $signed(sb); return p[31:0]; end
            default:    begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int op_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (!f[2]) return MUL_LAT;
        return 32;
    endfunction

    // Cycle model: expected busy/done/result for the cycle following each edge.
    logic        exp_busy = 1'b0, exp_done = 1'b0;
    logic [31:0] exp_result = 32'd0, pend_val = 32'd0;
    int          pend = 0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (reset) begin
            pend = 0; exp_busy = 1'b0; exp_result = 32'd0;
        end else if (flush) begin
            pend = 0; exp_busy = 1'b0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                exp_busy = 1'b0; exp_done = 1'b1; exp_result = pend_val;
            end
        end else if (start) begin
            if (op_latency(funct3, op_a, op_b) == 1) begin
                exp_done = 1'b1; exp_result = ref_op(funct3, op_a, op_b);
            end else begin
                pend = 31; exp_busy = 1'b1; pend_val = ref_op(funct3, op_a, op_b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", {31'd0, busy}, {31'd0, exp_busy});
            check("cyc done", {31'd0, done}, {31'd0, exp_done});
            check("cyc result", result, exp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Launch in the current cycle, wait (bounded) for done, check latency and value.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " value"}, result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);

        // multiplies, issued back-to-back
        run_op("MUL", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("MULH", MDU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("MULHU", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("MULHSU", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("MULH neg", MDU_MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, MUL_LAT);
        repeat (2) tick();

        // divides; each one starts in the previous done cycle
        run_op("DIV", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run_op("REM", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run_op("DIVU", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32);
        run_op("REMU", MDU_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32);
        run_op("DIVU 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 32);
        run_op("REMU 100/7", MDU_REMU, 32'd100, 32'd7, 32'd2, 32);
        tick();

        // special cases
        run_op("DIVU by0", MDU_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REM by0", MDU_REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("DIV ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        tick();

        // flush at T+10, new MUL launched at T+11
        funct3 = MDU_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result kept", result, 32'd0);
        run_op("MUL after flush", MDU_MUL, 32'd12345, 32'd1000, 32'h00BC_5EA8, MUL_LAT);
        tick();

        // flush together with start in IDLE discards the start
        funct3 = MDU_DIVU; op_a = 32'd10; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {31'd0, busy}, 32'd0);
        tick();
        check("flush+start busy2", {31'd0, busy}, 32'd0);

        // reset at T+5 of a DIV
        funct3 = MDU_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        tick();

        // start held high while busy, with changing operands
        funct3 = MDU_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        tick();
        cyc = 1;
        for (int i = 0; i < 20; i++) begin
            funct3 = MDU_REMU; op_a = 32'(i * 13 + 1); op_b = 32'd5;
            tick();
            cyc++;
        end
        start = 1'b0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("held start latency", 32'(cyc), 32'd32);
        check("held start value", result, 32'd14);

        // back-to-back: second op starts in the done cycle of the first
        run_op("b2b DIV", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32);
        run_op("b2b REM", MDU_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 32);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
